// File: rtl/muldiv_unit_if.sv
// Bus bundle for muldiv_unit: operation request, MTHI/MTLO writes, status and HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Requester side (CPU pipeline or testbench)
  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  // Unit side
  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Signed operations work on magnitudes and fix the signs in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t           state_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // Operation latched at start; a_r/b_r keep the raw operands for the special cases
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  // Datapath: opnd_r is multiplicand or divisor magnitude.
  // Multiply: {acc_hi_r, acc_lo_r} is the shifting product, acc_lo_r starts as multiplier.
  // Divide:   acc_hi_r is the partial remainder, acc_lo_r shifts dividend out / quotient in.
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r;   // product or quotient must be negated
  logic             neg_r_r;   // remainder must be negated (dividend was negative)

  logic             is_div_s;
  logic             is_signed_s;
  logic             sign_a_s;
  logic             sign_b_s;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_part_s;
  logic [WIDTH+1:0] div_diff_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic               div0_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic               res_dbz_s;

  // Magnitude of x when treated as signed; most-negative maps to 2^(WIDTH-1) unsigned
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      abs_val = -x;
    end else begin
      abs_val = x;
    end
  endfunction

  assign is_div_s    = op_r[1];
  assign is_signed_s = op_r[0];
  assign sign_a_s    = is_signed_s & a_r[WIDTH-1];
  assign sign_b_s    = is_signed_s & b_r[WIDTH-1];

  // One iteration step of the selected algorithm
  always_comb begin
    mul_sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_part_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_diff_s = {1'b0, div_part_s} - {2'b00, opnd_r};
    step_hi_s  = acc_hi_r;
    step_lo_s  = acc_lo_r;
    if (is_div_s) begin
      if (div_diff_s[WIDTH+1]) begin
        // Borrow: restore, quotient bit 0
        step_hi_s = div_part_s[WIDTH-1:0];
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end else begin
        step_hi_s = div_diff_s[WIDTH-1:0];
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Sign correction and special-case selection of the final HI/LO values
  always_comb begin
    prod_s     = {acc_hi_r, acc_lo_r};
    prod_fix_s = neg_q_r ? -prod_s : prod_s;
    quo_fix_s  = neg_q_r ? -acc_lo_r : acc_lo_r;
    rem_fix_s  = neg_r_r ? -acc_hi_r : acc_hi_r;
    div0_s     = (b_r == {WIDTH{1'b0}});
    ovf_s      = is_signed_s && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == {WIDTH{1'b1}});
    res_hi_s   = {WIDTH{1'b0}};
    res_lo_s   = {WIDTH{1'b0}};
    res_dbz_s  = 1'b0;
    if (!is_div_s) begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end else if (div0_s) begin
      res_hi_s  = a_r;
      res_lo_s  = {WIDTH{1'b1}};
      res_dbz_s = 1'b1;
    end else if (ovf_s) begin
      res_hi_s = {WIDTH{1'b0}};
      res_lo_s = a_r;
    end else begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end
  end

  // Control FSM with datapath registers and registered status/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      op_r     <= 2'b00;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.hi_we) begin
            hi_r <= bus.wdata;
          end
          if (bus.lo_we) begin
            lo_r <= bus.wdata;
          end
          if (bus.start) begin
            op_r    <= bus.op;
            a_r     <= bus.a;
            b_r     <= bus.b;
            busy_r  <= 1'b1;
            state_r <= PREP;
          end
        end
        PREP: begin
          acc_hi_r <= {WIDTH{1'b0}};
          cnt_r    <= CW'(WIDTH - 1);
          neg_q_r  <= sign_a_s ^ sign_b_s;
          if (is_div_s) begin
            acc_lo_r <= abs_val(a_r, is_signed_s);
            opnd_r   <= abs_val(b_r, is_signed_s);
            neg_r_r  <= sign_a_s;
          end else begin
            acc_lo_r <= abs_val(b_r, is_signed_s);
            opnd_r   <= abs_val(a_r, is_signed_s);
            neg_r_r  <= 1'b0;
          end
          state_r <= ITER;
        end
        ITER: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          hi_r    <= res_hi_s;
          lo_r    <= res_lo_s;
          dbz_r   <= res_dbz_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  muldiv_unit_if #(.WIDTH(32)) if32 ();
  muldiv_unit_if #(.WIDTH(8))  if8  ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Run one operation on the 32-bit unit; optional injections at cycle k after E0
  task automatic run_op(input string tag, input logic [1:0] op_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz, input int inj_start, input int inj_we,
                        input logic we_same);
    int lat;
    int busy_n;
    if32.op    = op_i;
    if32.a     = a_i;
    if32.b     = b_i;
    if32.start = 1'b1;
    if (we_same) begin
      if32.hi_we = 1'b1;
      if32.wdata = 32'h0000C0DE;
    end
    tick();
    if32.start = 1'b0;
    if32.hi_we = 1'b0;
    if32.op    = ~op_i;
    if32.a     = ~a_i;
    if32.b     = b_i ^ 32'h5A5A5A5A;
    if (we_same) chk({tag, "_we"}, 64'(if32.hi), 64'h0000C0DE);
    lat = -1;
    busy_n = 0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      if (if32.busy) busy_n++;
      if (k == inj_start) begin
        if32.start = 1'b1;
        if32.op    = 2'b11;
        if32.a     = 32'h00000064;
        if32.b     = 32'h00000003;
      end
      if (k == inj_we) begin
        if32.hi_we = 1'b1;
        if32.wdata = 32'hDEADBEEF;
      end
      tick();
      if32.start = 1'b0;
      if32.hi_we = 1'b0;
      if (if32.done) lat = k;
    end
    chk({tag, "_lat"},  64'(lat),    64'd34);
    chk({tag, "_busy"}, 64'(busy_n), 64'd34);
    chk({tag, "_hi"},   64'(if32.hi), 64'(exp_hi));
    chk({tag, "_lo"},   64'(if32.lo), 64'(exp_lo));
    chk({tag, "_dbz"},  64'(if32.div_by_zero), 64'(exp_dbz));
    tick();
    chk({tag, "_done_off"}, 64'(if32.done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_n;
    int lat8;
    rst = 1'b1;
    if32.start = 1'b0; if32.op = 2'b00; if32.a = 32'h0; if32.b = 32'h0;
    if32.hi_we = 1'b0; if32.lo_we = 1'b0; if32.wdata = 32'h0;
    if8.start = 1'b0;  if8.op = 2'b00;  if8.a = 8'h0;   if8.b = 8'h0;
    if8.hi_we = 1'b0;  if8.lo_we = 1'b0; if8.wdata = 8'h0;
    tick();
    tick();
    chk("rst_busy", 64'(if32.busy), 64'd0);
    chk("rst_done", 64'(if32.done), 64'd0);
    chk("rst_dbz",  64'(if32.div_by_zero), 64'd0);
    chk("rst_hi",   64'(if32.hi), 64'd0);
    chk("rst_lo",   64'(if32.lo), 64'd0);
    chk("rst_hi8",  64'(if8.hi), 64'd0);
    rst = 1'b0;

    // Idle MTHI then MTLO
    if32.hi_we = 1'b1; if32.wdata = 32'hA5A5A5A5;
    tick();
    if32.hi_we = 1'b0;
    chk("mthi_hi", 64'(if32.hi), 64'hA5A5A5A5);
    chk("mthi_lo", 64'(if32.lo), 64'h0);
    if32.lo_we = 1'b1; if32.wdata = 32'h5A5A0F0F;
    tick();
    if32.lo_we = 1'b0;
    chk("mtlo_lo", 64'(if32.lo), 64'h5A5A0F0F);
    chk("mtlo_hi", 64'(if32.hi), 64'hA5A5A5A5);

    // Arithmetic cases
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 0, 1'b0);
    run_op("div_neg",  2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0, 1'b0);
    run_op("divu",     2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 0, 0, 1'b0);
    run_op("divu_0",   2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 0, 0, 1'b0);
    run_op("div_ovf",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 0, 1'b0);
    run_op("div_mix",  2'b11, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 0, 0, 1'b0);
    run_op("multu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 10, 5, 1'b0);
    run_op("same_cyc", 2'b00, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, 0, 0, 1'b1);

    // Abort by reset mid-operation; reset beats start and hi_we at the same edge
    if32.op = 2'b01; if32.a = 32'h00001234; if32.b = 32'h00000011; if32.start = 1'b1;
    tick();
    if32.start = 1'b0;
    done_n = 0;
    for (int k = 1; k < 15; k++) begin
      tick();
      if (if32.done) done_n++;
    end
    rst = 1'b1; if32.start = 1'b1; if32.hi_we = 1'b1; if32.wdata = 32'hFFFF0000;
    tick();
    if (if32.done) done_n++;
    rst = 1'b0; if32.start = 1'b0; if32.hi_we = 1'b0;
    chk("abort_busy", 64'(if32.busy), 64'd0);
    chk("abort_hi",   64'(if32.hi), 64'd0);
    chk("abort_lo",   64'(if32.lo), 64'd0);
    chk("abort_done", 64'(done_n), 64'd0);
    run_op("after_rst", 2'b01, 32'h00000006, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 0, 0, 1'b0);

    // 8-bit instance: MULT -128 x -128
    if8.op = 2'b01; if8.a = 8'h80; if8.b = 8'h80; if8.start = 1'b1;
    tick();
    if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00;
    lat8 = -1;
    for (int k = 1; k <= 30 && lat8 < 0; k++) begin
      tick();
      if (if8.done) lat8 = k;
    end
    chk("w8_lat", 64'(lat8), 64'd10);
    chk("w8_hi",  64'(if8.hi), 64'h40);
    chk("w8_lo",  64'(if8.lo), 64'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
